// File: rtl/alu_mdu.sv
// Single-cycle ALU plus an iterative multiply/divide unit with HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per cycle for WIDTH cycles.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [4:0]       ALUctr,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OpAdd   = 5'b00000;
  localparam logic [4:0] OpSub   = 5'b00001;
  localparam logic [4:0] OpSlt   = 5'b00010;
  localparam logic [4:0] OpAnd   = 5'b00011;
  localparam logic [4:0] OpNor   = 5'b00100;
  localparam logic [4:0] OpOr    = 5'b00101;
  localparam logic [4:0] OpXor   = 5'b00110;
  localparam logic [4:0] OpSll   = 5'b00111;
  localparam logic [4:0] OpSrl   = 5'b01000;
  localparam logic [4:0] OpSltu  = 5'b01001;
  localparam logic [4:0] OpSllv  = 5'b01100;
  localparam logic [4:0] OpSra   = 5'b01101;
  localparam logic [4:0] OpSrav  = 5'b01110;
  localparam logic [4:0] OpSrlv  = 5'b01111;
  localparam logic [4:0] OpLui   = 5'b10000;
  localparam logic [4:0] OpMult  = 5'b10001;
  localparam logic [4:0] OpMultu = 5'b10010;
  localparam logic [4:0] OpDiv   = 5'b10011;
  localparam logic [4:0] OpDivu  = 5'b10100;
  localparam logic [4:0] OpMfhi  = 5'b10101;
  localparam logic [4:0] OpMflo  = 5'b10110;
  localparam logic [4:0] OpMthi  = 5'b10111;
  localparam logic [4:0] OpMtlo  = 5'b11000;

  localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               state_q;
  logic                 busy_q, done_q;
  logic [SHW-1:0]       cnt_q;
  logic [WIDTH-1:0]     opnd_q, dvd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]   work_q;
  logic                 neg_q, neg_rem_q;

  logic                 is_mul, is_div, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, r_shift, diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign is_mul    = (ALUctr == OpMult) || (ALUctr == OpMultu);
  assign is_div    = (ALUctr == OpDiv) || (ALUctr == OpDivu);
  assign signed_op = (ALUctr == OpMult) || (ALUctr == OpDiv);
  assign a_neg     = signed_op & busA[WIDTH-1];
  assign b_neg     = signed_op & busB[WIDTH-1];
  assign a_abs     = a_neg ? -busA : busA;
  assign b_abs     = b_neg ? -busB : busB;

  // work_q holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    r_shift  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    diff     = r_shift - {1'b0, opnd_q};
    div_next = diff[WIDTH] ? {r_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -mul_next : mul_next;
    quot_fix = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      work_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start && (is_mul || is_div)) begin
            state_q   <= is_mul ? StMul : StDiv;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            opnd_q    <= is_mul ? a_abs : b_abs;
            work_q    <= is_mul ? {{WIDTH{1'b0}}, b_abs} : {{WIDTH{1'b0}}, a_abs};
            dvd_q     <= busA;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
          end else if (start && ALUctr == OpMthi) begin
            hi_q <= busA;
          end else if (start && ALUctr == OpMtlo) begin
            lo_q <= busA;
          end
        end
        StMul: begin
          work_q <= mul_next;
          cnt_q  <= cnt_q + SHW'(1);
          if (cnt_q == LastCnt) begin
            {hi_q, lo_q} <= prod_fix;
            state_q      <= StDone;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        StDiv: begin
          work_q <= div_next;
          cnt_q  <= cnt_q + SHW'(1);
          if (cnt_q == LastCnt) begin
            // A zero divisor bypasses the sign fix-up: HI gets the raw dividend.
            if (opnd_q == '0) begin
              hi_q <= dvd_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Result = '0;
    case (ALUctr)
      OpAdd:  Result = busA + busB;
      OpSub:  Result = busA - busB;
      OpAnd:  Result = busA & busB;
      OpNor:  Result = ~(busA | busB);
      OpOr:   Result = busA | busB;
      OpXor:  Result = busA ^ busB;
      OpSlt:  Result = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(busB)};
      OpSltu: Result = {{(WIDTH-1){1'b0}}, busA < busB};
      OpSll:  Result = busB << shamt;
      OpSrl:  Result = busB >> shamt;
      OpSra:  Result = $signed(busB) >>> shamt;
      OpSllv: Result = busB << busA[SHW-1:0];
      OpSrlv: Result = busB >> busA[SHW-1:0];
      OpSrav: Result = $signed(busB) >>> busA[SHW-1:0];
      OpLui:  Result = busB << (WIDTH / 2);
      OpMfhi: Result = hi_q;
      OpMflo: Result = lo_q;
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed and randomized checks of alu_mdu against an arithmetic reference model.
module tb_alu_mdu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLT = 5'b00010, SLTU = 5'b01001;
  localparam logic [4:0] SRA = 5'b01101, MULT = 5'b10001, MULTU = 5'b10010;
  localparam logic [4:0] DIV = 5'b10011, DIVU = 5'b10100, MFHI = 5'b10101;
  localparam logic [4:0] MTHI = 5'b10111, MTLO = 5'b11000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] busA, busB;
  logic [4:0]  ALUctr;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] Result, hi, lo;
  logic        Zero, busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo;

  alu_mdu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .busA(busA), .busB(busB), .ALUctr(ALUctr), .shamt(shamt),
    .start(start), .Result(Result), .Zero(Zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      5'b00000: t = sa + sb;
      5'b00001: t = sa - sb;
      5'b00010: t = (sa < sb) ? 1 : 0;
      5'b01001: t = ({32'h0, a} < {32'h0, b}) ? 1 : 0;
      5'b00011: t = longint'(a & b);
      5'b00100: t = longint'(~(a | b));
      5'b00101: t = longint'(a | b);
      5'b00110: t = longint'(a ^ b);
      5'b00111: t = longint'({32'h0, b}) * (longint'(1) << sh);
      5'b01000: t = longint'({32'h0, b}) / (longint'(1) << sh);
      5'b01101: t = sb >>> sh;
      5'b01100: t = longint'({32'h0, b}) * (longint'(1) << a[4:0]);
      5'b01111: t = longint'({32'h0, b}) / (longint'(1) << a[4:0]);
      5'b01110: t = sb >>> a[4:0];
      5'b10000: t = longint'({32'h0, b}) * 65536;
      5'b10101: t = longint'({32'h0, m_hi});
      5'b10110: t = longint'({32'h0, m_lo});
      default:  t = 0;
    endcase
    return t[31:0];
  endfunction

  task automatic ref_mdu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = (c == MULT || c == DIV) ? longint'($signed(a)) : longint'({32'h0, a});
    sb = (c == MULT || c == DIV) ? longint'($signed(b)) : longint'({32'h0, b});
    if (c == MULT || c == MULTU) begin
      p = (c == MULT) ? 64'(sa * sb) : {32'h0, a} * {32'h0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input string tag, input logic [4:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] e;
    ALUctr = c; busA = a; busB = b; shamt = sh;
    #1;
    e = ref_alu(c, a, b, sh);
    chk(tag, Result, e);
    chk({tag, "_zero"}, Zero, e == 0);
  endtask

  // launched: op was already started by the caller; chain: issue a MULTU 3*5 in the DONE cycle.
  task automatic run_mdu(input string tag, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit launched, input bit poke,
                         input bit chain);
    int busy_n, done_n, done_at;
    logic [31:0] eh, el, pre_hi;
    ref_mdu(c, a, b, eh, el);
    pre_hi = m_hi;
    if (!launched) begin
      ALUctr = c; busA = a; busB = b; start = 1'b1;
      cyc();
    end
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = i;
          chk({tag, "_hi"}, hi, eh);
          chk({tag, "_lo"}, lo, el);
          m_hi = eh; m_lo = el;
        end
        if (chain) begin
          chk({tag, "_busy_cnt"}, busy_n, 32);
          chk({tag, "_done_at"}, done_at, 33);
          ALUctr = MULTU; busA = 32'd3; busB = 32'd5; start = 1'b1;
          cyc();
          start = 1'b0;
          chk({tag, "_b2b_busy"}, busy, 1'b1);
          return;
        end
      end
      if (poke && i == 5) begin
        ALUctr = MFHI; #1;
        chk({tag, "_mfhi_busy"}, Result, pre_hi);
      end
      if (poke && i == 7) comb({tag, "_add_busy"}, ADD, $urandom, $urandom, 5'd0);
      if (poke && i == 10) begin
        ALUctr = MULT; busA = $urandom; busB = $urandom; start = 1'b1;
      end
      if (poke && i == 12) begin
        ALUctr = MTHI; busA = 32'hDEAD_0001; start = 1'b1;
      end
      if (poke && i == 14) chk({tag, "_hi_busy"}, hi, pre_hi);
      cyc();
      start = 1'b0;
    end
    chk({tag, "_busy_cnt"}, busy_n, 32);
    chk({tag, "_done_at"}, done_at, 33);
    chk({tag, "_done_cnt"}, done_n, 1);
  endtask

  initial begin
    int done_n;
    logic [4:0] c;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; busA = '0; busB = '0; ALUctr = '0; shamt = '0;
    m_hi = '0; m_lo = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst_n = 1'b1;
    cyc();

    comb("slt_neg", SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    comb("sltu_big", SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
    comb("sra4", SRA, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra4_const", Result, 32'hF800_0000);
    comb("sub_zero", SUB, 32'd5, 32'd5, 5'd0);
    chk("sub_zero_flag", Zero, 1'b1);
    for (int k = 0; k < 150; k++) begin
      c = 5'($urandom_range(0, 31));
      comb("rand_alu", c, $urandom, (k % 7 == 0) ? 32'h0 : $urandom, 5'($urandom));
    end

    ALUctr = MTHI; busA = 32'h0000_ABCD; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("mthi_hi", hi, 32'h0000_ABCD);
    chk("mthi_done", done, 1'b0);
    m_hi = 32'h0000_ABCD;
    ALUctr = MTLO; busA = 32'h1357_9BDF; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h1357_9BDF);
    m_lo = 32'h1357_9BDF;

    run_mdu("mult", MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    run_mdu("multu", MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b0);
    chk("multu_hi_const", hi, 32'h1);
    run_mdu("div", DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b1, 1'b0);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    run_mdu("divu", DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    chk("divu_lo_const", lo, 32'd14);
    run_mdu("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    run_mdu("divu_zero", DIVU, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("divu_zero_lo_const", lo, 32'hFFFF_FFFF);
    run_mdu("div_zero", DIV, 32'h8765_4321, 32'h0, 1'b0, 1'b0, 1'b0);

    run_mdu("chain1", DIV, 32'hFFFF_FF00, 32'd7, 1'b0, 1'b0, 1'b1);
    run_mdu("chain2", MULTU, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
    chk("chain2_lo_const", lo, 32'd15);

    for (int k = 0; k < 12; k++) begin
      c = 5'(MULT + 5'($urandom_range(0, 3)));
      a = $urandom;
      b = (k % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (k == 5) b = 32'h0;
      run_mdu("rand_mdu", c, a, b, 1'b0, (k % 3 == 0), 1'b0);
    end

    ALUctr = MULT; busA = 32'h1234_5678; busB = 32'h9ABC_DEF0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    rst_n = 1'b0; ALUctr = MTHI; busA = 32'h0000_4321; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_done", done, 1'b0);
    m_hi = '0; m_lo = '0;
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_n++;
      cyc();
    end
    chk("rst_mid_no_done", done_n, 0);
    chk("rst_mid_hi_after", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
